// File: rtl/mu0_core_if.sv
// Memory bus between the MU0 core and memory_32x16.
// Reads are combinational: mem_rdata follows mem_addr within the same cycle.
// A write commits on the rising clock edge while memrq=1 and rw=0.
interface mu0_core_if;
    logic [11:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        memrq;
    logic        rw;

    modport master (
        output mem_addr,
        output mem_wdata,
        output memrq,
        output rw,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr,
        input  mem_wdata,
        input  memrq,
        input  rw,
        output mem_rdata
    );
endinterface

// File: rtl/mu0_core.sv
// MU0 accumulator processor core: fetch/execute controller and datapath.
// Runs the 8-instruction MU0 ISA at two cycles per instruction until STP.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | after reset, memory idle, waits for run
//   FETCH  | reads [PC] into IR, PC increments
//   EXEC   | decodes IR, addresses [S], performs the operation
//   HALT   | stopped after STP (or illegal opcode), left only by rst
module mu0_core #(
    parameter logic [11:0] RESET_PC        = 12'h000,
    parameter bit          HALT_ON_ILLEGAL = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          run,
    mu0_core_if.master    bus,
    output logic          halted,
    output logic [15:0]   acc_out,
    output logic [11:0]   pc_out
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_STO = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_JMP = 4'h4;
    localparam logic [3:0] OP_JGE = 4'h5;
    localparam logic [3:0] OP_JNE = 4'h6;
    localparam logic [3:0] OP_STP = 4'h7;

    state_t      state;
    state_t      state_next;
    logic [11:0] pc;
    logic [11:0] pc_next;
    logic [15:0] ir;
    logic [15:0] ir_next;
    logic [15:0] acc;
    logic [15:0] acc_next;

    logic [3:0]  opcode;
    logic [11:0] operand;
    logic        mem_req;
    logic        mem_rw;
    logic [11:0] mem_addr;

    assign opcode  = ir[15:12];
    assign operand = ir[11:0];

    // State and datapath registers; reset clears everything immediately so a
    // write in progress is dropped before its clock edge arrives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            pc    <= RESET_PC;
            ir    <= 16'h0000;
            acc   <= 16'h0000;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            ir    <= ir_next;
            acc   <= acc_next;
        end
    end

    // Next-state, datapath update and memory control decode. Memory outputs
    // depend only on registered state so the address is stable all cycle.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        ir_next    = ir;
        acc_next   = acc;
        mem_req    = 1'b0;
        mem_rw     = 1'b1;
        mem_addr   = pc;

        case (state)
            ST_IDLE: begin
                if (run) begin
                    state_next = ST_FETCH;
                end
            end

            ST_FETCH: begin
                mem_req    = 1'b1;
                ir_next    = bus.mem_rdata;
                pc_next    = pc + 12'd1;
                state_next = ST_EXEC;
            end

            ST_EXEC: begin
                mem_addr   = operand;
                state_next = ST_FETCH;
                case (opcode)
                    OP_LDA: begin
                        mem_req  = 1'b1;
                        acc_next = bus.mem_rdata;
                    end
                    OP_STO: begin
                        mem_req = 1'b1;
                        mem_rw  = 1'b0;
                    end
                    OP_ADD: begin
                        mem_req  = 1'b1;
                        acc_next = acc + bus.mem_rdata;
                    end
                    OP_SUB: begin
                        mem_req  = 1'b1;
                        acc_next = acc - bus.mem_rdata;
                    end
                    OP_JMP: begin
                        pc_next = operand;
                    end
                    OP_JGE: begin
                        if (!acc[15]) begin
                            pc_next = operand;
                        end
                    end
                    OP_JNE: begin
                        if (acc != 16'h0000) begin
                            pc_next = operand;
                        end
                    end
                    OP_STP: begin
                        state_next = ST_HALT;
                    end
                    default: begin
                        // Opcodes 8..F: no memory access; either stop or fall through.
                        if (HALT_ON_ILLEGAL) begin
                            state_next = ST_HALT;
                        end
                    end
                endcase
            end

            ST_HALT: begin
                state_next = ST_HALT;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign bus.mem_addr  = mem_addr;
    assign bus.mem_wdata = acc;
    assign bus.memrq     = mem_req;
    assign bus.rw        = mem_rw;

    assign halted  = (state == ST_HALT);
    assign acc_out = acc;
    assign pc_out  = pc;

endmodule

// File: tb/tb_mu0_core.sv
// Bench for mu0_core: a 32x16 memory model per core, a bus scoreboard that
// checks every memory request against an expected queue, and a halt
// scoreboard that checks ACC/PC whenever the core enters HALT.
module tb_mu0_core;

    typedef struct packed {
        logic        rw;
        logic [11:0] addr;
        logic [15:0] wdata;
    } bus_t;

    typedef struct packed {
        logic [15:0] acc;
        logic [11:0] pc;
    } halt_t;

    logic clk = 1'b0;
    logic rst;
    logic run;
    logic run1;

    logic        halted0;
    logic [15:0] acc0;
    logic [11:0] pc0;
    logic        halted1;
    logic [15:0] acc1;
    logic [11:0] pc1;

    logic        ld_en;
    logic        ld_sel;
    logic        clr;
    logic [4:0]  ld_addr;
    logic [15:0] ld_data;

    logic [15:0] mem0 [32];
    logic [15:0] mem1 [32];

    int checks = 0;
    int errors = 0;

    bus_t  exp_bus [$];
    halt_t exp_halt [$];
    bus_t  got_bus;
    halt_t got_halt;
    logic  prev_h0 = 1'b0;

    mu0_core_if bus0 ();
    mu0_core_if bus1 ();

    mu0_core #(.RESET_PC(12'h000), .HALT_ON_ILLEGAL(1'b0)) dut0 (
        .clk     (clk),
        .rst     (rst),
        .run     (run),
        .bus     (bus0.master),
        .halted  (halted0),
        .acc_out (acc0),
        .pc_out  (pc0)
    );

    mu0_core #(.RESET_PC(12'h000), .HALT_ON_ILLEGAL(1'b1)) dut1 (
        .clk     (clk),
        .rst     (rst),
        .run     (run1),
        .bus     (bus1.master),
        .halted  (halted1),
        .acc_out (acc1),
        .pc_out  (pc1)
    );

    always #5 clk = ~clk;

    assign bus0.mem_rdata = mem0[bus0.mem_addr[4:0]];
    assign bus1.mem_rdata = mem1[bus1.mem_addr[4:0]];

    // Memory models: bench loads/clears, plus core writes on the rising edge.
    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 32; i++) begin
                mem0[i] <= 16'h0000;
                mem1[i] <= 16'h0000;
            end
        end else if (ld_en) begin
            if (ld_sel) mem1[ld_addr] <= ld_data;
            else        mem0[ld_addr] <= ld_data;
        end else begin
            if (bus0.memrq && !bus0.rw) mem0[bus0.mem_addr[4:0]] <= bus0.mem_wdata;
            if (bus1.memrq && !bus1.rw) mem1[bus1.mem_addr[4:0]] <= bus1.mem_wdata;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    // Bus monitor: every memory request must match the next expected one.
    always @(negedge clk) begin
        if (bus0.memrq) begin
            if (exp_bus.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL bus_unexpected actual rw=%b addr=%h required none", bus0.rw, bus0.mem_addr);
            end else begin
                got_bus = exp_bus.pop_front();
                chk("bus_rw", {31'd0, bus0.rw}, {31'd0, got_bus.rw});
                chk("bus_addr", {20'd0, bus0.mem_addr}, {20'd0, got_bus.addr});
                if (!got_bus.rw) chk("bus_wdata", {16'd0, bus0.mem_wdata}, {16'd0, got_bus.wdata});
            end
        end
    end

    // Halt monitor: on entry to HALT compare ACC and PC with the expected result.
    always @(negedge clk) begin
        if (halted0 && !prev_h0) begin
            if (exp_halt.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL halt_unexpected actual pc=%h required none", pc0);
            end else begin
                got_halt = exp_halt.pop_front();
                chk("halt_acc", {16'd0, acc0}, {16'd0, got_halt.acc});
                chk("halt_pc", {20'd0, pc0}, {20'd0, got_halt.pc});
            end
        end
        prev_h0 <= halted0;
    end

    task automatic pf(input logic [11:0] a);
        exp_bus.push_back({1'b1, a, 16'h0000});
    endtask

    task automatic pw(input logic [11:0] a, input logic [15:0] d);
        exp_bus.push_back({1'b0, a, d});
    endtask

    task automatic ph(input logic [15:0] a, input logic [11:0] p);
        exp_halt.push_back({a, p});
    endtask

    task automatic load(input logic sel, input logic [4:0] a, input logic [15:0] d);
        @(negedge clk);
        ld_sel  = sel;
        ld_addr = a;
        ld_data = d;
        ld_en   = 1'b1;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        rst = 1'b0;
    endtask

    task automatic run_halt(input string nm, input int exp_n, input bit chk_stp);
        int  n = 0;
        bit  done = 1'b0;
        @(negedge clk);
        run = 1'b1;
        @(posedge clk);
        #1 run = 1'b0;
        while (!done && n < 400) begin
            @(posedge clk);
            #1;
            n++;
            if (chk_stp && n == exp_n - 1) chk({nm, "_stp_memrq"}, {31'd0, bus0.memrq}, 32'd0);
            if (halted0) done = 1'b1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout actual no halt required halt after %0d edges", nm, exp_n);
        end else begin
            chk({nm, "_edges"}, n, exp_n);
        end
        @(negedge clk);
        #1;
        chk({nm, "_bus_left"}, exp_bus.size(), 0);
        chk({nm, "_halt_left"}, exp_halt.size(), 0);
    endtask

    task automatic load_t2();
        load(1'b0, 5'd0, 16'h0010);
        load(1'b0, 5'd1, 16'h2011);
        load(1'b0, 5'd2, 16'h1012);
        load(1'b0, 5'd3, 16'h7000);
        load(1'b0, 5'd16, 16'h0005);
        load(1'b0, 5'd17, 16'h0003);
    endtask

    initial begin
        int n;
        rst = 1'b1; run = 1'b0; run1 = 1'b0;
        ld_en = 1'b0; ld_sel = 1'b0; clr = 1'b0; ld_addr = 5'd0; ld_data = 16'h0;

        // Reset values
        #12;
        chk("rst_memrq", {31'd0, bus0.memrq}, 32'd0);
        chk("rst_rw", {31'd0, bus0.rw}, 32'd1);
        chk("rst_addr", {20'd0, bus0.mem_addr}, 32'h000);
        chk("rst_wdata", {16'd0, bus0.mem_wdata}, 32'h0000);
        chk("rst_halted", {31'd0, halted0}, 32'd0);
        do_reset();

        // T1: reset in the FETCH of the second instruction, ACC already 5
        load_t2();
        pf(12'h000); pf(12'h010);
        @(negedge clk);
        run = 1'b1;
        @(posedge clk);
        #1 run = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3;
        chk("t1_pre_pc", {20'd0, pc0}, 32'h001);
        chk("t1_pre_acc", {16'd0, acc0}, 32'h0005);
        rst = 1'b1;
        #1;
        chk("t1_memrq", {31'd0, bus0.memrq}, 32'd0);
        chk("t1_rw", {31'd0, bus0.rw}, 32'd1);
        chk("t1_pc", {20'd0, pc0}, 32'h000);
        chk("t1_acc", {16'd0, acc0}, 32'h0000);
        chk("t1_halted", {31'd0, halted0}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("t1_bus_left", exp_bus.size(), 0);

        // T2: load/add/store, STP; halted after 8 edges
        pf(12'h000); pf(12'h010);
        pf(12'h001); pf(12'h011);
        pf(12'h002); pw(12'h012, 16'h0008);
        pf(12'h003);
        ph(16'h0008, 12'h004);
        run_halt("t2", 8, 1'b1);
        chk("t2_mem18", {16'd0, mem0[18]}, 32'h0008);

        // T3: countdown loop from 3
        do_reset();
        load(1'b0, 5'd0, 16'h0010);
        load(1'b0, 5'd1, 16'h3011);
        load(1'b0, 5'd2, 16'h1010);
        load(1'b0, 5'd3, 16'h6000);
        load(1'b0, 5'd4, 16'h7000);
        load(1'b0, 5'd16, 16'h0003);
        load(1'b0, 5'd17, 16'h0001);
        pf(12'h000); pf(12'h010); pf(12'h001); pf(12'h011); pf(12'h002); pw(12'h010, 16'h0002); pf(12'h003);
        pf(12'h000); pf(12'h010); pf(12'h001); pf(12'h011); pf(12'h002); pw(12'h010, 16'h0001); pf(12'h003);
        pf(12'h000); pf(12'h010); pf(12'h001); pf(12'h011); pf(12'h002); pw(12'h010, 16'h0000); pf(12'h003);
        pf(12'h004);
        ph(16'h0000, 12'h005);
        run_halt("t3", 26, 1'b0);
        chk("t3_mem16", {16'd0, mem0[16]}, 32'h0000);

        // T4: JGE not taken on 8000, taken on 0000
        do_reset();
        load(1'b0, 5'd0, 16'h0010);
        load(1'b0, 5'd1, 16'h5009);
        load(1'b0, 5'd2, 16'h0011);
        load(1'b0, 5'd3, 16'h5009);
        load(1'b0, 5'd9, 16'h7000);
        load(1'b0, 5'd16, 16'h8000);
        load(1'b0, 5'd17, 16'h0000);
        pf(12'h000); pf(12'h010);
        pf(12'h001);
        pf(12'h002); pf(12'h011);
        pf(12'h003);
        pf(12'h009);
        ph(16'h0000, 12'h00A);
        run_halt("t4", 10, 1'b0);

        // T5: reset during STO EXEC, then a clean rerun
        do_reset();
        load(1'b0, 5'd0, 16'h0010);
        load(1'b0, 5'd1, 16'h1011);
        load(1'b0, 5'd2, 16'h7000);
        load(1'b0, 5'd16, 16'h00AA);
        load(1'b0, 5'd17, 16'h1234);
        pf(12'h000); pf(12'h010); pf(12'h001);
        @(negedge clk);
        run = 1'b1;
        @(posedge clk);
        #1 run = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("t5_sto_rw", {31'd0, bus0.rw}, 32'd0);
        chk("t5_sto_addr", {20'd0, bus0.mem_addr}, 32'h011);
        #1 rst = 1'b1;
        #1;
        chk("t5_rst_memrq", {31'd0, bus0.memrq}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("t5_mem17", {16'd0, mem0[17]}, 32'h1234);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t5_idle_memrq", {31'd0, bus0.memrq}, 32'd0);
            chk("t5_idle_pc", {20'd0, pc0}, 32'h000);
        end
        chk("t5_bus_left", exp_bus.size(), 0);
        pf(12'h000); pf(12'h010); pf(12'h001); pw(12'h011, 16'h00AA); pf(12'h002);
        ph(16'h00AA, 12'h003);
        run_halt("t5", 6, 1'b0);
        chk("t5_mem17_rerun", {16'd0, mem0[17]}, 32'h00AA);

        // T6: opcode 9000 as NOP (dut0) and as halt (dut1)
        do_reset();
        load(1'b0, 5'd0, 16'h9000);
        load(1'b0, 5'd1, 16'h7000);
        load(1'b1, 5'd0, 16'h9000);
        load(1'b1, 5'd1, 16'h7000);
        pf(12'h000); pf(12'h001);
        ph(16'h0000, 12'h002);
        run_halt("t6_nop", 4, 1'b0);

        @(negedge clk);
        run1 = 1'b1;
        @(posedge clk);
        #1 run1 = 1'b0;
        n = 0;
        while (!halted1 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 1) chk("t6_halt_exec_memrq", {31'd0, bus1.memrq}, 32'd0);
        end
        chk("t6_halt_edges", n, 2);
        chk("t6_halt_halted", {31'd0, halted1}, 32'd1);
        chk("t6_halt_pc", {20'd0, pc1}, 32'h001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual timeout required finish");
        $fatal(1, "watchdog");
    end

endmodule
